// File: rtl/logic_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pkg : op-code encoding shared by the pipelined logic unit      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package logic_unit_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOT  = 3'b000;
    localparam op_t OP_AND  = 3'b001;
    localparam op_t OP_OR   = 3'b010;
    localparam op_t OP_XOR  = 3'b011;
    localparam op_t OP_NAND = 3'b100;
    localparam op_t OP_NOR  = 3'b101;
    localparam op_t OP_XNOR = 3'b110;
    localparam op_t OP_PASS = 3'b111;

endpackage
`default_nettype wire

// File: rtl/logic_unit_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_stage : one valid/data pipeline register with its ready term   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module logic_unit_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          can_next,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          can
);

    // An empty stage, or one whose contents move on this cycle, may load.
    assign can = !valid || can_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (can) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_pipe : pipelined 8-function bitwise logic unit, valid/ready    |
// | Optional macro LOGIC_UNIT_FLAGS_EN adds zero_flag / parity_flag outputs.  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             parity_flag
`endif
);

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam int FLAG_W = 2;
`else
    localparam int FLAG_W = 0;
`endif
    localparam int DW = WIDTH + FLAG_W;

    logic             ready_en;
    logic             in_fire;
    logic [WIDTH-1:0] result;
    logic [DW-1:0]    stage_in;
    logic [STAGES:0]  can;
    logic [STAGES-1:0] v;
    logic [DW-1:0]    d [STAGES];

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready = ready_en && can[0];
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        result = a;
        case (op_t'(op))
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            default: result = a;
        endcase
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    assign stage_in = {~|result, ^result, result};
`else
    assign stage_in = result;
`endif

    assign can[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic          up_v;
        logic [DW-1:0] up_d;
        if (i == 0) begin : g_first
            assign up_v = in_fire;
            assign up_d = stage_in;
        end else begin : g_rest
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end
        logic_unit_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (up_v),
            .up_data  (up_d),
            .can_next (can[i+1]),
            .valid    (v[i]),
            .data     (d[i]),
            .can      (can[i])
        );
    end

    assign out_valid = v[STAGES-1];
    assign z         = d[STAGES-1][WIDTH-1:0];

`ifdef LOGIC_UNIT_FLAGS_EN
    assign zero_flag   = d[STAGES-1][WIDTH+1];
    assign parity_flag = d[STAGES-1][WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
